// File: rtl/led_frame_buffer_pkg.sv
// led_pkg: shared geometry, colour codes and FSM state encoding for the LED frame buffer.
package led_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam logic [1:0] COLOR_OFF = 2'b00;
  localparam logic [1:0] COLOR_RED = 2'b01;
  localparam logic [1:0] COLOR_GREEN = 2'b10;
  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;
endpackage

// File: rtl/led_frame_buffer_if.sv
// led_frame_buffer_if: pixel-write/control bus and front-buffer outputs of the frame buffer.
interface led_frame_buffer_if;
  import led_pkg::*;
  logic wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [1:0] wr_color;
  logic clear;
  logic swap_req;
  logic [ROWS-1:0][COLS-1:0] red_array;
  logic [ROWS-1:0][COLS-1:0] green_array;
  logic busy;
  logic swap_ack;
  modport master(output wr_en, wr_row, wr_col, wr_color, clear, swap_req,
                 input red_array, green_array, busy, swap_ack);
  modport slave(input wr_en, wr_row, wr_col, wr_color, clear, swap_req,
                output red_array, green_array, busy, swap_ack);
endinterface

// File: rtl/led_frame_buffer_scan_counter.sv
// led_scan_counter: free-running 3-bit row counter, shared by the buffer and the matrix driver.
module led_scan_counter (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] count
);
  always_ff @(posedge clk) count <= reset ? 3'd0 : count + 3'd1;
endmodule

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered 8x8 red/green frame store with row-wise clear and scan-aligned swap.
module led_frame_buffer
  import led_pkg::*;
#(
  parameter bit ALIGN_SWAP = 1'b1
) (
  input logic clk,
  input logic reset,
  led_frame_buffer_if.slave bus
);
  state_t r_state, w_next;
  logic [2:0] w_scan, r_row;
  logic [ROWS-1:0][COLS-1:0] r_back_red, r_back_green, r_front_red, r_front_green;
  logic r_swap_ack, w_write, w_swap;
  led_scan_counter u_scan (.clk(clk), .reset(reset), .count(w_scan));
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_write = (r_state == IDLE) && bus.wr_en && !bus.clear;
    w_swap = (r_state == SWAP_WAIT) && (!ALIGN_SWAP || w_scan == 3'd7);
    w_next = (r_state == IDLE) ? (bus.clear ? CLEAR : bus.swap_req ? SWAP_WAIT : IDLE)
           : (r_state == CLEAR) ? ((r_row == 3'd7) ? IDLE : CLEAR)
           : (w_swap ? IDLE : SWAP_WAIT);
  end
  // Swap is a copy: the back planes keep their contents for further edits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_back_red <= '0;
      r_back_green <= '0;
      r_front_red <= '0;
      r_front_green <= '0;
      r_row <= 3'd0;
      r_swap_ack <= 1'b0;
    end else begin
      r_swap_ack <= w_swap;
      if (w_write) begin
        r_back_red[bus.wr_row][bus.wr_col] <= bus.wr_color[0];
        r_back_green[bus.wr_row][bus.wr_col] <= bus.wr_color[1];
      end
      if (r_state == CLEAR) begin
        r_back_red[r_row] <= '0;
        r_back_green[r_row] <= '0;
        r_row <= r_row + 3'd1;
      end
      if (w_swap) begin
        r_front_red <= r_back_red;
        r_front_green <= r_back_green;
      end
    end
  end
  assign bus.red_array = r_front_red;
  assign bus.green_array = r_front_green;
  assign bus.busy = (r_state != IDLE);
  assign bus.swap_ack = r_swap_ack;
endmodule

// File: tb/tb_led_frame_buffer.sv
// tb_led_frame_buffer: directed tests of the frame buffer with aligned (u1) and immediate (u0) swap variants.
module tb_led_frame_buffer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wr_en = 1'b0, clear = 1'b0, swap_req = 1'b0;
  logic [2:0] wr_row = 3'd0, wr_col = 3'd0;
  logic [1:0] wr_color = 2'd0;
  int errors = 0, checks = 0, cyc = 0;
  led_frame_buffer_if b1 ();
  led_frame_buffer_if b0 ();
  assign b1.wr_en = wr_en;
  assign b1.wr_row = wr_row;
  assign b1.wr_col = wr_col;
  assign b1.wr_color = wr_color;
  assign b1.clear = clear;
  assign b1.swap_req = swap_req;
  assign b0.wr_en = wr_en;
  assign b0.wr_row = wr_row;
  assign b0.wr_col = wr_col;
  assign b0.wr_color = wr_color;
  assign b0.clear = clear;
  assign b0.swap_req = swap_req;
  led_frame_buffer #(.ALIGN_SWAP(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  led_frame_buffer #(.ALIGN_SWAP(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    {wr_en, clear, swap_req} = 3'b000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic write(input logic [2:0] r, input logic [2:0] c, input logic [1:0] col);
    wr_en = 1'b1;
    wr_row = r;
    wr_col = c;
    wr_color = col;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fill_ones();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) write(3'(r), 3'(c), 2'b11);
  endtask

  task automatic swap_wait(output bit ok);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (b1.swap_ack === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    write(3'd1, 3'd1, 2'b11);
    swap_wait(ok);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (b1.red_array !== 64'd0) begin errors++; $display("FAIL reset_red got=%h exp=0", b1.red_array); end
    checks++;
    if (b1.green_array !== 64'd0) begin errors++; $display("FAIL reset_green got=%h exp=0", b1.green_array); end
    checks++;
    if (b1.busy !== 1'b0 || b0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b/%b exp=0/0", b1.busy, b0.busy); end
    checks++;
    if (b1.swap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", b1.swap_ack); end
  endtask

  task automatic test_basic_swap();
    bit ok, early;
    do_reset();
    write(3'd3, 3'd5, 2'b01);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    ok = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (b1.swap_ack === 1'b1) ok = 1'b1;
      else begin
        if (b1.red_array !== 64'd0) early = 1'b1;
        tick();
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_ack got=timeout exp=ack"); end
    checks++;
    if (early) begin errors++; $display("FAIL basic_early got=front changed before ack exp=unchanged"); end
    checks++;
    if (cyc % 8 != 0) begin errors++; $display("FAIL basic_align got=scan %0d exp=scan 0", cyc % 8); end
    checks++;
    if (b1.red_array !== (64'd1 << 29)) begin errors++; $display("FAIL basic_red got=%h exp=%h", b1.red_array, 64'd1 << 29); end
    checks++;
    if (b1.green_array !== 64'd0) begin errors++; $display("FAIL basic_green got=%h exp=0", b1.green_array); end
    checks++;
    if (b1.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", b1.busy); end
  endtask

  task automatic test_overwrite();
    bit ok;
    do_reset();
    write(3'd0, 3'd0, 2'b11);
    write(3'd0, 3'd0, 2'b10);
    swap_wait(ok);
    checks++;
    if (!ok || b1.red_array !== 64'd0) begin errors++; $display("FAIL over_red got=%h ack=%b exp=0", b1.red_array, ok); end
    checks++;
    if (b1.green_array !== 64'd1) begin errors++; $display("FAIL over_green got=%h exp=1", b1.green_array); end
  endtask

  task automatic test_clear();
    bit ok;
    do_reset();
    fill_ones();
    swap_wait(ok);
    checks++;
    if (!ok || b1.red_array !== '1 || b1.green_array !== '1) begin
      errors++; $display("FAIL fill_front got=%h/%h exp=all ones", b1.red_array, b1.green_array);
    end
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (b1.busy !== 1'b1) begin errors++; $display("FAIL clear_busy%0d got=%b exp=1", i, b1.busy); end
      write(3'(7 - i), 3'd2, 2'b11);
    end
    checks++;
    if (b1.busy !== 1'b0) begin errors++; $display("FAIL clear_done got=%b exp=0", b1.busy); end
    checks++;
    if (b1.red_array !== '1) begin errors++; $display("FAIL clear_front got=%h exp=all ones", b1.red_array); end
    swap_wait(ok);
    checks++;
    if (!ok || b1.red_array !== 64'd0 || b1.green_array !== 64'd0) begin
      errors++; $display("FAIL clear_swap got=%h/%h ack=%b exp=0/0", b1.red_array, b1.green_array, ok);
    end
  endtask

  task automatic test_clear_swap();
    bit ok, acked;
    do_reset();
    write(3'd4, 3'd4, 2'b01);
    swap_wait(ok);
    tick();
    write(3'd6, 3'd6, 2'b10);
    clear = 1'b1;
    swap_req = 1'b1;
    tick();
    {clear, swap_req} = 2'b00;
    acked = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (b1.swap_ack === 1'b1 || b0.swap_ack === 1'b1) acked = 1'b1;
      tick();
    end
    checks++;
    if (acked) begin errors++; $display("FAIL cs_ack got=ack exp=none"); end
    checks++;
    if (b1.red_array !== (64'd1 << 36) || b1.green_array !== 64'd0) begin
      errors++; $display("FAIL cs_front got=%h/%h exp=%h/0", b1.red_array, b1.green_array, 64'd1 << 36);
    end
    swap_wait(ok);
    checks++;
    if (!ok || b1.red_array !== 64'd0 || b1.green_array !== 64'd0) begin
      errors++; $display("FAIL cs_cleared got=%h/%h exp=0/0", b1.red_array, b1.green_array);
    end
  endtask

  task automatic test_align();
    logic [63:0] px;
    px = 64'h8000_0000_0000_0000;
    do_reset();
    write(3'd7, 3'd7, 2'b11);
    while (cyc < 8) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    while (cyc <= 17) begin
      if (cyc == 9) begin
        checks++;
        if (b0.red_array !== 64'd0 || b0.swap_ack !== 1'b0) begin errors++; $display("FAIL a0_pre got=%h ack=%b exp=0 ack=0", b0.red_array, b0.swap_ack); end
      end
      if (cyc == 10) begin
        checks++;
        if (b0.red_array !== px || b0.green_array !== px || b0.swap_ack !== 1'b1) begin errors++; $display("FAIL a0_upd got=%h ack=%b exp=%h ack=1", b0.red_array, b0.swap_ack, px); end
      end
      if (cyc == 11) begin
        checks++;
        if (b0.swap_ack !== 1'b0) begin errors++; $display("FAIL a0_pulse got=%b exp=0", b0.swap_ack); end
      end
      if (cyc == 15) begin
        checks++;
        if (b1.red_array !== 64'd0 || b1.swap_ack !== 1'b0 || b1.busy !== 1'b1) begin errors++; $display("FAIL a1_pre got=%h ack=%b busy=%b exp=0 ack=0 busy=1", b1.red_array, b1.swap_ack, b1.busy); end
      end
      if (cyc == 16) begin
        checks++;
        if (b1.red_array !== px || b1.green_array !== px || b1.swap_ack !== 1'b1) begin errors++; $display("FAIL a1_upd got=%h ack=%b exp=%h ack=1", b1.red_array, b1.swap_ack, px); end
      end
      if (cyc == 17) begin
        checks++;
        if (b1.swap_ack !== 1'b0) begin errors++; $display("FAIL a1_pulse got=%b exp=0", b1.swap_ack); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_clear();
    bit ok;
    do_reset();
    fill_ones();
    swap_wait(ok);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
    checks++;
    if (b1.red_array !== 64'd0 || b1.green_array !== 64'd0 || b1.busy !== 1'b0 || b1.swap_ack !== 1'b0) begin
      errors++; $display("FAIL rmc_out got=%h/%h busy=%b ack=%b exp=0/0 busy=0 ack=0", b1.red_array, b1.green_array, b1.busy, b1.swap_ack);
    end
    swap_wait(ok);
    checks++;
    if (!ok || b1.red_array !== 64'd0 || b1.green_array !== 64'd0) begin
      errors++; $display("FAIL rmc_back got=%h/%h ack=%b exp=0/0", b1.red_array, b1.green_array, ok);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n0;
    do_reset();
    write(3'd1, 3'd2, 2'b01);
    swap_req = 1'b1;
    n1 = 0;
    n0 = 0;
    while (cyc < 25) begin
      tick();
      n1 += int'(b1.swap_ack === 1'b1);
      n0 += int'(b0.swap_ack === 1'b1);
    end
    swap_req = 1'b0;
    checks++;
    if (n1 != 3) begin errors++; $display("FAIL b2b_aligned got=%0d exp=3", n1); end
    checks++;
    if (n0 != 12) begin errors++; $display("FAIL b2b_immediate got=%0d exp=12", n0); end
    checks++;
    if (b1.red_array !== (64'd1 << 10)) begin errors++; $display("FAIL b2b_front got=%h exp=%h", b1.red_array, 64'd1 << 10); end
  endtask

  initial begin
    test_reset();
    test_basic_swap();
    test_overwrite();
    test_clear();
    test_clear_swap();
    test_align();
    test_reset_mid_clear();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
